// File: rtl/redbus_pkg.sv
// Shared types and constants for the Redbus window controller.
package redbus_pkg;

  typedef enum logic [1:0] {
    MMU_SET_DEV  = 2'd0,
    MMU_SET_BASE = 2'd1,
    MMU_ENABLE   = 2'd2,
    MMU_DISABLE  = 2'd3
  } mmu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] RB_TIMEOUT_DATA = 8'hFF;
  localparam int         WINDOW_SPAN     = 256;

endpackage

// File: rtl/redbus_window_decode.sv
// Window hit and offset decode for the Redbus window.
module redbus_window_decode
  import redbus_pkg::*;
(
  input  logic [15:0] addr_i,
  input  logic [15:0] base_i,
  input  logic        en_i,
  output logic        hit_o,
  output logic [7:0]  off_o
);

  logic [16:0] a_w;
  logic [16:0] lo_w;
  logic [16:0] hi_w;

  // 17-bit compare so a window near the top never wraps to 0
  assign a_w   = {1'b0, addr_i};
  assign lo_w  = {1'b0, base_i};
  assign hi_w  = lo_w + 17'(WINDOW_SPAN - 1);
  assign hit_o = en_i && (a_w >= lo_w) && (a_w <= hi_w);
  assign off_o = addr_i[7:0] - base_i[7:0];

endmodule

// File: rtl/redbus_window.sv
// CPU-side Redbus window: decodes window hits into Redbus
// strobes, stalls until ack or timeout, MMU-op configuration.
module redbus_window
  import redbus_pkg::*;
#(
  parameter int          TIMEOUT    = 15,
  parameter logic [15:0] RESET_BASE = 16'h0300
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] CpuAddress,
  input  logic [7:0]  CpuWriteData,
  input  logic        CpuRead,
  input  logic        CpuWrite,
  output logic [7:0]  CpuReadData,
  output logic        CpuReady,
  output logic        CpuHit,
  input  logic        MmuStrobe,
  input  logic [1:0]  MmuOp,
  input  logic [15:0] MmuData,
  output logic [7:0]  RbDevice,
  output logic [15:0] Address,
  output logic [7:0]  RbWriteData,
  input  logic [7:0]  RbReadData,
  output logic        ReadRedbus,
  output logic        WriteRedbus,
  input  logic        RbAck,
  output logic        TimeoutFlag
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [7:0]  off_q, off_d;
  logic        rd_q, rd_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        tflag_q, tflag_d;
  logic [15:0] base_q, base_d;
  logic [7:0]  dev_q, dev_d;
  logic        en_q, en_d;
  logic        pvld_q, pvld_d;
  mmu_op_e     pop_q, pop_d;
  logic [15:0] pdata_q, pdata_d;

  logic        apply;
  mmu_op_e     op;
  logic [15:0] data;
  logic [7:0]  off_w;

  redbus_window_decode u_dec (
    .addr_i (CpuAddress),
    .base_i (base_q),
    .en_i   (en_q),
    .hit_o  (CpuHit),
    .off_o  (off_w)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    off_d   = off_q;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    tflag_d = tflag_q;
    base_d  = base_q;
    dev_d   = dev_q;
    en_d    = en_q;
    pvld_d  = pvld_q;
    pop_d   = pop_q;
    pdata_d = pdata_q;
    apply   = 1'b0;
    op      = mmu_op_e'(MmuOp);
    data    = MmuData;
    if (MmuStrobe) tflag_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        apply = MmuStrobe;
        if (CpuHit && (CpuRead || CpuWrite)) begin
          off_d   = off_w;
          rd_d    = CpuRead;
          wdata_d = CpuWriteData;
          timer_d = 8'd0;
          state_d = BUS;
        end
      end
      BUS: begin
        if (MmuStrobe) begin
          pvld_d  = 1'b1;
          pop_d   = mmu_op_e'(MmuOp);
          pdata_d = MmuData;
        end
        if (RbAck) begin
          state_d = DONE;
          if (rd_q) rdata_d = RbReadData;
        end else if (timer_q == TMO_LAST) begin
          state_d = DONE;
          rdata_d = RB_TIMEOUT_DATA;
          tflag_d = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      DONE: begin
        // a strobe arriving in DONE supersedes the pending one
        state_d = IDLE;
        apply   = MmuStrobe || pvld_q;
        pvld_d  = 1'b0;
        if (!MmuStrobe) begin
          op   = pop_q;
          data = pdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (apply) begin
      unique case (op)
        MMU_SET_DEV:  dev_d  = data[7:0];
        MMU_SET_BASE: base_d = data;
        MMU_ENABLE:   en_d   = 1'b1;
        MMU_DISABLE:  en_d   = 1'b0;
        default:      en_d   = en_q;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      off_q   <= '0;
      rd_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      tflag_q <= 1'b0;
      base_q  <= RESET_BASE;
      dev_q   <= '0;
      en_q    <= 1'b0;
      pvld_q  <= 1'b0;
      pop_q   <= MMU_SET_DEV;
      pdata_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      off_q   <= off_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      tflag_q <= tflag_d;
      base_q  <= base_d;
      dev_q   <= dev_d;
      en_q    <= en_d;
      pvld_q  <= pvld_d;
      pop_q   <= pop_d;
      pdata_q <= pdata_d;
    end
  end

  assign CpuReady    = (state_q == DONE);
  assign CpuReadData = rdata_q;
  assign ReadRedbus  = (state_q == BUS) && rd_q;
  assign WriteRedbus = (state_q == BUS) && !rd_q;
  assign Address     = {8'h00, off_q};
  assign RbWriteData = wdata_q;
  assign RbDevice    = dev_q;
  assign TimeoutFlag = tflag_q;

endmodule

// File: tb/tb_redbus_window.sv
// Directed self-checking bench for redbus_window.
module tb_redbus_window;
  import redbus_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] CpuAddress = '0;
  logic [7:0]  CpuWriteData = '0;
  logic        CpuRead = 1'b0;
  logic        CpuWrite = 1'b0;
  logic [7:0]  CpuReadData;
  logic        CpuReady;
  logic        CpuHit;
  logic        MmuStrobe = 1'b0;
  logic [1:0]  MmuOp = '0;
  logic [15:0] MmuData = '0;
  logic [7:0]  RbDevice;
  logic [15:0] Address;
  logic [7:0]  RbWriteData;
  logic [7:0]  RbReadData = '0;
  logic        ReadRedbus;
  logic        WriteRedbus;
  logic        RbAck = 1'b0;
  logic        TimeoutFlag;

  int n_run  = 0;
  int n_fail = 0;

  redbus_window #(.TIMEOUT(15), .RESET_BASE(16'h0300)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .CpuAddress   (CpuAddress),
    .CpuWriteData (CpuWriteData),
    .CpuRead      (CpuRead),
    .CpuWrite     (CpuWrite),
    .CpuReadData  (CpuReadData),
    .CpuReady     (CpuReady),
    .CpuHit       (CpuHit),
    .MmuStrobe    (MmuStrobe),
    .MmuOp        (MmuOp),
    .MmuData      (MmuData),
    .RbDevice     (RbDevice),
    .Address      (Address),
    .RbWriteData  (RbWriteData),
    .RbReadData   (RbReadData),
    .ReadRedbus   (ReadRedbus),
    .WriteRedbus  (WriteRedbus),
    .RbAck        (RbAck),
    .TimeoutFlag  (TimeoutFlag)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic mmu(input logic [1:0] op, input logic [15:0] d);
    MmuStrobe = 1'b1;
    MmuOp     = op;
    MmuData   = d;
    tick();
    MmuStrobe = 1'b0;
  endtask

  initial begin
    int n;
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    tick();
    check("rst_ready", CpuReady, 0);
    check("rst_rd", ReadRedbus, 0);
    check("rst_wr", WriteRedbus, 0);
    check("rst_addr", Address, 16'h0000);
    check("rst_dev", RbDevice, 0);
    check("rst_tflag", TimeoutFlag, 0);
    CpuAddress = 16'h0305;
    check("rst_nohit", CpuHit, 0);

    mmu(MMU_SET_DEV, 16'h0002);
    mmu(MMU_SET_BASE, 16'h0300);
    mmu(MMU_ENABLE, 16'h0000);

    // read with ack in second BUS cycle
    CpuRead = 1'b1;
    check("r_hit", CpuHit, 1);
    tick();
    check("r_strobe1", ReadRedbus, 1);
    check("r_addr", Address, 16'h0005);
    check("r_dev", RbDevice, 8'h02);
    check("r_noready", CpuReady, 0);
    tick();
    check("r_strobe2", ReadRedbus, 1);
    RbAck = 1'b1;
    RbReadData = 8'h5A;
    tick();
    RbAck = 1'b0;
    check("r_ready", CpuReady, 1);
    check("r_data", CpuReadData, 8'h5A);
    check("r_strobe_off", ReadRedbus, 0);
    CpuRead = 1'b0;
    tick();
    check("r_ready_one", CpuReady, 0);

    // write with immediate ack
    CpuAddress = 16'h0380;
    CpuWriteData = 8'h11;
    CpuWrite = 1'b1;
    RbAck = 1'b1;
    tick();
    check("w_strobe", WriteRedbus, 1);
    check("w_rdoff", ReadRedbus, 0);
    check("w_addr", Address, 16'h0080);
    check("w_data", RbWriteData, 8'h11);
    tick();
    check("w_ready", CpuReady, 1);
    CpuWrite = 1'b0;
    RbAck = 1'b0;
    tick();

    // timeout
    CpuAddress = 16'h0310;
    CpuRead = 1'b1;
    tick();
    n = 0;
    while (ReadRedbus && n < 40) begin
      n++;
      tick();
    end
    check("to_cycles", 16'(n), 16'd15);
    check("to_ready", CpuReady, 1);
    check("to_data", CpuReadData, 8'hFF);
    check("to_flag", TimeoutFlag, 1);
    CpuRead = 1'b0;
    tick();
    check("to_sticky", TimeoutFlag, 1);
    mmu(MMU_ENABLE, 16'h0000);
    check("to_clear", TimeoutFlag, 0);

    // window boundaries
    CpuAddress = 16'h02FF;
    CpuRead = 1'b1;
    #1;
    check("b_02ff", CpuHit, 0);
    tick();
    check("b_02ff_strb", ReadRedbus, 0);
    check("b_02ff_rdy", CpuReady, 0);
    CpuAddress = 16'h0400;
    #1;
    check("b_0400", CpuHit, 0);
    tick();
    check("b_0400_strb", ReadRedbus, 0);
    CpuRead = 1'b0;
    CpuAddress = 16'h0300;
    #1;
    check("b_0300", CpuHit, 1);
    CpuAddress = 16'h03FF;
    #1;
    check("b_03ff", CpuHit, 1);
    mmu(MMU_SET_BASE, 16'hFF80);
    CpuAddress = 16'h0000;
    #1;
    check("b_nowrap", CpuHit, 0);
    CpuAddress = 16'hFFFF;
    #1;
    check("b_ffff", CpuHit, 1);
    mmu(MMU_SET_BASE, 16'h0300);

    // base change during BUS is deferred
    CpuAddress = 16'h0305;
    CpuRead = 1'b1;
    tick();
    mmu(MMU_SET_BASE, 16'h0500);
    check("p_addr", Address, 16'h0005);
    check("p_strobe", ReadRedbus, 1);
    RbAck = 1'b1;
    RbReadData = 8'h77;
    tick();
    RbAck = 1'b0;
    check("p_ready", CpuReady, 1);
    check("p_data", CpuReadData, 8'h77);
    CpuRead = 1'b0;
    tick();
    CpuAddress = 16'h0500;
    #1;
    check("p_newhit", CpuHit, 1);
    CpuAddress = 16'h0305;
    #1;
    check("p_oldmiss", CpuHit, 0);

    // reset mid-BUS
    CpuAddress = 16'h0500;
    CpuRead = 1'b1;
    tick();
    check("x_strobe", ReadRedbus, 1);
    Reset = 1'b1;
    #1;
    check("x_async", ReadRedbus, 0);
    check("x_ready0", CpuReady, 0);
    tick();
    check("x_ready1", CpuReady, 0);
    Reset = 1'b0;
    #1;
    check("x_disabled", CpuHit, 0);
    tick();
    check("x_ready2", CpuReady, 0);
    check("x_nostrobe", ReadRedbus, 0);
    check("x_dev", RbDevice, 0);
    CpuRead = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
